// File: rtl/butterfly_4_pipe.sv
// Registered 4-point even/odd butterfly with a two-entry (output + skid) buffer
// and a row counter that tags each row with its index in a 4-row block.
module butterfly_4_pipe #(
  parameter int unsigned IN_W = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_clear,
  input  logic signed [IN_W-1:0] i_0,
  input  logic signed [IN_W-1:0] i_1,
  input  logic signed [IN_W-1:0] i_2,
  input  logic signed [IN_W-1:0] i_3,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [IN_W:0]   o_0,
  output logic signed [IN_W:0]   o_1,
  output logic signed [IN_W:0]   o_2,
  output logic signed [IN_W:0]   o_3,
  output logic [1:0]             o_row,
  output logic                   o_last
);

  localparam int unsigned OUT_W = IN_W + 1;

  logic                    acc_in;
  logic                    acc_out;
  logic [1:0]              cnt;
  logic [1:0]              cnt_next;
  logic [1:0]              row_tag;
  logic signed [OUT_W-1:0] ext_0, ext_1, ext_2, ext_3;
  logic signed [OUT_W-1:0] sum_0, sum_1, dif_2, dif_3;

  logic                    skid_valid;
  logic signed [OUT_W-1:0] skid_0, skid_1, skid_2, skid_3;
  logic [1:0]              skid_row;

  // Ready depends only on registered state, never on i_ready.
  assign o_ready = ~skid_valid & ~rst;
  assign acc_in  = i_valid & o_ready;
  assign acc_out = o_valid & i_ready;
  assign o_last  = o_valid & (o_row == 2'd3);

  // Sign-extend one bit so sums and differences cannot overflow.
  assign ext_0 = OUT_W'(i_0);
  assign ext_1 = OUT_W'(i_1);
  assign ext_2 = OUT_W'(i_2);
  assign ext_3 = OUT_W'(i_3);
  assign sum_0 = ext_0 + ext_3;
  assign sum_1 = ext_1 + ext_2;
  assign dif_2 = ext_1 - ext_2;
  assign dif_3 = ext_0 - ext_3;

  // Row tag / counter: i_clear restarts the block at row 0.
  always_comb begin
    row_tag  = i_clear ? 2'd0 : cnt;
    cnt_next = cnt;
    if (acc_in) begin
      cnt_next = row_tag + 2'd1;
    end else if (i_clear) begin
      cnt_next = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // OUT refills from SKID first, then from the input; otherwise overflow goes to SKID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_0        <= '0;
      o_1        <= '0;
      o_2        <= '0;
      o_3        <= '0;
      o_row      <= 2'd0;
      skid_valid <= 1'b0;
      skid_0     <= '0;
      skid_1     <= '0;
      skid_2     <= '0;
      skid_3     <= '0;
      skid_row   <= 2'd0;
    end else if (acc_out || !o_valid) begin
      if (skid_valid) begin
        o_valid    <= 1'b1;
        o_0        <= skid_0;
        o_1        <= skid_1;
        o_2        <= skid_2;
        o_3        <= skid_3;
        o_row      <= skid_row;
        skid_valid <= 1'b0;
      end else if (acc_in) begin
        o_valid <= 1'b1;
        o_0     <= sum_0;
        o_1     <= sum_1;
        o_2     <= dif_2;
        o_3     <= dif_3;
        o_row   <= row_tag;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (acc_in) begin
      skid_valid <= 1'b1;
      skid_0     <= sum_0;
      skid_1     <= sum_1;
      skid_2     <= dif_2;
      skid_3     <= dif_3;
      skid_row   <= row_tag;
    end
  end

endmodule

// File: tb/tb_butterfly_4_pipe.sv
// Scoreboard bench for butterfly_4_pipe: a negedge monitor predicts each accepted
// row and compares it when the DUT hands it downstream.
module tb_butterfly_4_pipe;

  localparam int unsigned IN_W = 27;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid, i_clear, i_ready;
  logic                   o_ready, o_valid, o_last;
  logic signed [IN_W-1:0] i_0, i_1, i_2, i_3;
  logic signed [IN_W:0]   o_0, o_1, o_2, o_3;
  logic [1:0]             o_row;

  typedef struct {
    longint v0, v1, v2, v3;
    logic [1:0] row;
  } exp_t;

  exp_t   q[$];
  exp_t   e_pop;
  exp_t   e_push;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     rows_in  = 0;
  int     rows_out = 0;
  bit     rec_en   = 1'b0;
  int     obs_row[$];
  int     obs_last[$];
  logic [1:0] m_cnt = 2'd0;
  bit     stall_prev = 1'b0;
  longint h0, h1, h2, h3, h_row;

  butterfly_4_pipe #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_clear(i_clear),
    .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_0(o_0), .o_1(o_1), .o_2(o_2), .o_3(o_3),
    .o_row(o_row), .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable at the negedge, so the handshakes seen here happen at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt      = 2'd0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", longint'(o_valid), 1);
        check("stall_o_0", longint'(o_0), h0);
        check("stall_o_1", longint'(o_1), h1);
        check("stall_o_2", longint'(o_2), h2);
        check("stall_o_3", longint'(o_3), h3);
        check("stall_row", longint'(o_row), h_row);
      end
      if (o_valid && i_ready) begin
        check("sb_underflow", longint'(q.size() == 0), 0);
        if (q.size() > 0) begin
          e_pop = q.pop_front();
          check("sb_o_0", longint'(o_0), e_pop.v0);
          check("sb_o_1", longint'(o_1), e_pop.v1);
          check("sb_o_2", longint'(o_2), e_pop.v2);
          check("sb_o_3", longint'(o_3), e_pop.v3);
          check("sb_o_row", longint'(o_row), longint'(e_pop.row));
          check("sb_o_last", longint'(o_last), longint'(e_pop.row == 2'd3));
        end
        rows_out++;
        if (rec_en) begin
          obs_row.push_back(int'(o_row));
          obs_last.push_back(int'(o_last));
        end
      end
      if (i_valid && o_ready) begin
        e_push.v0  = longint'(i_0) + longint'(i_3);
        e_push.v1  = longint'(i_1) + longint'(i_2);
        e_push.v2  = longint'(i_1) - longint'(i_2);
        e_push.v3  = longint'(i_0) - longint'(i_3);
        e_push.row = i_clear ? 2'd0 : m_cnt;
        m_cnt      = i_clear ? 2'd1 : m_cnt + 2'd1;
        q.push_back(e_push);
        rows_in++;
      end else if (i_clear) begin
        m_cnt = 2'd0;
      end
      stall_prev = o_valid && !i_ready;
      h0 = longint'(o_0); h1 = longint'(o_1); h2 = longint'(o_2); h3 = longint'(o_3);
      h_row = longint'(o_row);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint a, input longint b, input longint c, input longint d,
                       input bit clr);
    i_0 = IN_W'(a); i_1 = IN_W'(b); i_2 = IN_W'(c); i_3 = IN_W'(d);
    i_clear = clr;
    i_valid = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rows[9] = '{0, 1, 2, 3, 0, 1, 0, 1, 2};
    int r0, o0;

    rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
    i_0 = '0; i_1 = '0; i_2 = '0; i_3 = '0;
    repeat (2) step();
    check("rst_o_valid", longint'(o_valid), 0);
    check("rst_o_ready", longint'(o_ready), 0);
    check("rst_o_0", longint'(o_0), 0);
    check("rst_o_3", longint'(o_3), 0);
    check("rst_o_row", longint'(o_row), 0);
    check("rst_o_last", longint'(o_last), 0);
    rst = 1'b0;
    #1;
    check("rel_o_ready", longint'(o_ready), 1);

    // Basic arithmetic
    step();
    drive(100, -7, 5, -30, 1'b0);
    step();
    i_valid = 1'b0;
    check("basic_valid", longint'(o_valid), 1);
    check("basic_o_0", longint'(o_0), 70);
    check("basic_o_1", longint'(o_1), -2);
    check("basic_o_2", longint'(o_2), -12);
    check("basic_o_3", longint'(o_3), 130);
    check("basic_row", longint'(o_row), 0);

    // Extremes: no wrap thanks to the extra bit
    drive(67108863, -67108864, 67108863, 67108863, 1'b0);
    step();
    i_valid = 1'b0;
    check("ext_o_0", longint'(o_0), 134217726);
    check("ext_o_1", longint'(o_1), -1);
    check("ext_o_2", longint'(o_2), -134217727);
    check("ext_o_3", longint'(o_3), 0);
    step();

    // Row tagging with i_clear on rows 0 and 6
    obs_row.delete(); obs_last.delete(); rec_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(k, 2 * k, -k, 3, (k == 0) || (k == 6));
      step();
    end
    i_valid = 1'b0; i_clear = 1'b0;
    repeat (2) step();
    rec_en = 1'b0;
    check("tag_count", longint'(obs_row.size()), 9);
    for (int k = 0; k < 9; k++) begin
      check("tag_row", (k < obs_row.size()) ? longint'(obs_row[k]) : -1, longint'(exp_rows[k]));
      check("tag_last", (k < obs_last.size()) ? longint'(obs_last[k]) : -1, (k == 3) ? 1 : 0);
    end

    // Back-pressure: A and B buffered, C held off until release
    r0 = rows_in; o0 = rows_out;
    i_ready = 1'b0;
    drive(1000, 1, 2, 3, 1'b0);
    step();
    drive(2000, 4, 5, 6, 1'b0);
    check("bp_ready_after_a", longint'(o_ready), 1);
    step();
    check("bp_ready_full", longint'(o_ready), 0);
    check("bp_valid", longint'(o_valid), 1);
    check("bp_head_a", longint'(o_0), 1003);
    drive(3000, 7, 8, 9, 1'b0);
    repeat (3) begin
      step();
      check("bp_ready_hold", longint'(o_ready), 0);
      check("bp_head_hold", longint'(o_0), 1003);
    end
    i_ready = 1'b1;
    for (int t = 0; t < 10 && rows_in == r0 + 2; t++) step();
    i_valid = 1'b0;
    check("bp_accepted", longint'(rows_in - r0), 3);
    repeat (4) step();
    check("bp_drained", longint'(rows_out - o0), 3);
    check("bp_sb_empty", longint'(q.size()), 0);

    // Random handshakes over 1000 rows
    r0 = rows_in;
    for (int t = 0; t < 20000 && (rows_in - r0) < 1000; t++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_clear = ($urandom_range(0, 7) == 0);
      i_0 = IN_W'($urandom); i_1 = IN_W'($urandom);
      i_2 = IN_W'($urandom); i_3 = IN_W'($urandom);
      step();
    end
    i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
    check("rand_rows", longint'((rows_in - r0) >= 1000), 1);
    repeat (4) step();
    check("rand_sb_empty", longint'(q.size()), 0);

    // Reset while FULL
    i_ready = 1'b0;
    drive(11, 22, 33, 44, 1'b0);
    step();
    drive(55, 66, 77, 88, 1'b0);
    step();
    i_valid = 1'b0;
    check("full_ready", longint'(o_ready), 0);
    rst = 1'b1;
    #1;
    check("frst_valid", longint'(o_valid), 0);
    check("frst_ready", longint'(o_ready), 0);
    step();
    rst = 1'b0;
    #1;
    check("frel_valid", longint'(o_valid), 0);
    check("frel_ready", longint'(o_ready), 1);
    i_ready = 1'b1;
    drive(5, 6, 7, 8, 1'b0);
    step();
    i_valid = 1'b0;
    check("frel_out_valid", longint'(o_valid), 1);
    check("frel_row", longint'(o_row), 0);
    check("frel_o_0", longint'(o_0), 13);
    repeat (3) step();
    check("final_sb_empty", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly_4_pipe.md
# butterfly_4_pipe

Registered 4-point even/odd butterfly with valid/ready flow control and row tagging. It sits directly upstream of the 4-point output permutation stage in the transform datapath. Each accepted row of four signed samples produces one row of two sums and two differences, one cycle later. A two-entry buffer (output register plus skid register) absorbs downstream back-pressure without losing or duplicating rows.

## Interface
- IN_W, 27, signed input sample width; output width is IN_W+1 (default 28, matching the downstream permutation stage).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream row valid.
- o_ready  output  1  block can accept a row this cycle.
- i_clear  input  1  synchronous block-start marker (see Operation).
- i_0..i_3  input  IN_W each  signed input samples of one row.
- o_valid  output  1  output row valid.
- i_ready  input  1  downstream accepts output this cycle.
- o_0..o_3  output  IN_W+1 each  signed butterfly results.
- o_row  output  2  row index within the 4-row block, carried with the data.
- o_last  output  1  high with the row tagged o_row==3.

## Operation
- Input handshake: acc_in = i_valid & o_ready. Output handshake: acc_out = o_valid & i_ready.
- Arithmetic, with operands sign-extended to IN_W+1 before add/sub so that no overflow is possible:
  - o_0 = i_0 + i_3
  - o_1 = i_1 + i_2
  - o_2 = i_1 - i_2
  - o_3 = i_0 - i_3
- Row counter cnt[1:0], updated on each rising edge:
  - acc_in & ~i_clear: the row is tagged cnt, and cnt advances to cnt+1 (wraps 3 -> 0).
  - acc_in & i_clear: the row is tagged 0, and cnt becomes 1.
  - ~acc_in & i_clear: cnt becomes 0.
  - Otherwise cnt holds.
- o_last = (o_row == 3), qualified by o_valid.
- Storage has two entries. Each entry holds {o_0..o_3, o_row, valid}:
  - OUT is the head; it drives the outputs.
  - SKID is the overflow entry.
- Buffer states and transitions:
  - EMPTY (OUT invalid, SKID invalid):
    - acc_in -> ONE, with the computed row loaded into OUT.
  - ONE (OUT valid, SKID invalid):
    - acc_in & acc_out -> ONE, with OUT replaced by the new row.
    - acc_in & ~acc_out -> FULL, with the new row loaded into SKID.
    - ~acc_in & acc_out -> EMPTY.
  - FULL (both valid):
    - acc_out -> ONE, with SKID moved into OUT.
    - Input is never accepted while FULL.
- o_ready = ~SKID.valid & ~rst. It is a combinational function of registered state; there is no combinational path from i_ready to o_ready.
- OUT fields hold their values while o_valid & ~i_ready (outputs stay stable under stall).

## Timing
- Latency: a row accepted at edge N appears on o_* with o_valid=1 after edge N, provided OUT was empty or draining at edge N.
- Throughput: one row per cycle while i_ready=1.
- Reset (asynchronous assert, synchronous release):
  - o_valid=0, o_0..o_3=0, o_row=0, o_last=0, cnt=0, SKID cleared.
  - o_ready=0 while rst=1, and 1 in the first cycle after release.
- Reset mid-operation: all buffered rows are discarded and no partial row appears after release.
- Stall: at most two rows are buffered. o_ready drops in the cycle after the second row is captured.
- i_clear takes effect only at a clock edge. i_clear with no accepted input only re-arms the counter.

## Test plan
- Basic arithmetic, IN_W=27: i_0=100, i_1=-7, i_2=5, i_3=-30, single row -> one cycle later o_0=70, o_1=-2, o_2=-12, o_3=130, o_valid=1.
- Extremes: i_0=i_3=2^26-1, i_1=-2^26, i_2=2^26-1 -> o_0=2^27-2, o_1=-1, o_2=-2^27+1, o_3=0, with no wrap.
- Row tagging: stream 9 rows with i_clear pulsed alongside row 0 and row 6 -> o_row sequence 0,1,2,3,0,1,0,1,2; o_last high only on the 4th output row.
- Back-pressure: hold i_ready=0 while streaming rows A,B,C -> A and B are accepted, and o_ready=0 from the cycle after B is captured. Release i_ready -> outputs A,B,C appear in order with none dropped or duplicated, and o_* stay stable during the stall.
- Random handshakes: random i_valid/i_ready over 1000 rows -> output equals the reference model sequence, and no output changes while o_valid & ~i_ready.
- Reset in FULL state: assert rst for 1 cycle with two rows buffered -> o_valid=0 immediately, o_ready=0 during reset. After release, the next row accepted is tagged o_row=0.
